// File: rtl/dram_responder.sv
// dram_responder
//   Responder end of the data-RAM request interface. Requests from the EX stage
//   are accepted with an address handshake. Writes are byte-strobed into an
//   internal word array and retire at accept. Reads capture the addressed word
//   at accept and return it in order, after READ_LATENCY cycles, on a
//   registered response channel.
//
// Ports:
//   clk           clock
//   rst_b         synchronous reset, active-high
//   dram_req      request valid
//   dram_write    1 = write, 0 = read
//   dram_wstrb    byte write enables (writes only)
//   dram_addr     byte address; [1:0] and bits above the array index are ignored
//   dram_wdata    write data, lane-replicated by the requester
//   dram_addr_ok  request accepted this cycle if dram_req is also high
//   dram_data_ok  read response valid, one-cycle pulse per read
//   dram_rdata    read data, valid while dram_data_ok is high
//   stall_in      test back-pressure, forces dram_addr_ok low
module dram_responder #(
    parameter int XLEN         = 32,
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1,
    parameter int OUTSTANDING  = 2
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              dram_req,
    input  logic              dram_write,
    input  logic [XLEN/8-1:0] dram_wstrb,
    input  logic [XLEN-1:0]   dram_addr,
    input  logic [XLEN-1:0]   dram_wdata,
    output logic              dram_addr_ok,
    output logic              dram_data_ok,
    output logic [XLEN-1:0]   dram_rdata,
    input  logic              stall_in
);

    localparam int NBYTES = XLEN / 8;
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int AGE_W  = $clog2(READ_LATENCY + 1);
    localparam int CNT_W  = $clog2(OUTSTANDING + 1);

    localparam logic [AGE_W-1:0] LAT     = AGE_W'(READ_LATENCY);
    localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // One pending read: the word captured at accept and its age in cycles.
    typedef struct packed {
        logic [XLEN-1:0]  data;
        logic [AGE_W-1:0] age;
    } rsp_ent_t;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // Response FIFO kept as a shift queue: entry 0 is always the oldest read.
    rsp_ent_t         ent     [OUTSTANDING];
    rsp_ent_t         ent_nxt [OUTSTANDING];
    logic [CNT_W-1:0] rd_count;
    logic [CNT_W-1:0] cnt_nxt;
    logic             data_ok_nxt;
    logic [XLEN-1:0]  rdata_nxt;

    logic [IDX_W-1:0] idx;
    logic             acc;
    logic             rd_acc;
    logic             wr_acc;
    logic             unused_addr;

    assign idx         = dram_addr[IDX_W+1:2];
    assign unused_addr = ^{dram_addr[XLEN-1:IDX_W+2], dram_addr[1:0]};

    // No dependence on dram_req, so no loop through the requester. A full FIFO
    // blocks accept even in a pop cycle: there is no bypass.
    assign dram_addr_ok = ~rst_b & ~stall_in & (rd_count < CNT_MAX);
    assign acc          = dram_req & dram_addr_ok;
    assign rd_acc       = acc & ~dram_write;
    assign wr_acc       = acc & dram_write;

    // Next FIFO state, applied in order: pop the head whose response is on
    // the bus this cycle, age the survivors, push the new read, then decide
    // whether the (new) head is due on the registered response next cycle.
    always_comb begin
        ent_nxt     = ent;
        cnt_nxt     = rd_count;
        data_ok_nxt = 1'b0;
        rdata_nxt   = dram_rdata;

        if (dram_data_ok) begin
            for (int i = 0; i < OUTSTANDING - 1; i++) begin
                ent_nxt[i] = ent[i+1];
            end
            ent_nxt[OUTSTANDING-1] = '0;
            cnt_nxt = cnt_nxt - CNT_ONE;
        end

        for (int i = 0; i < OUTSTANDING; i++) begin
            if (CNT_W'(i) < cnt_nxt && ent_nxt[i].age != LAT) begin
                ent_nxt[i].age = ent_nxt[i].age + AGE_ONE;
            end
        end

        // Capturing at accept orders the read after every earlier write and
        // before every later one.
        if (rd_acc) begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                if (CNT_W'(i) == cnt_nxt) begin
                    ent_nxt[i].data = mem[idx];
                    ent_nxt[i].age  = AGE_ONE;
                end
            end
            cnt_nxt = cnt_nxt + CNT_ONE;
        end

        if (cnt_nxt != '0 && ent_nxt[0].age == LAT) begin
            data_ok_nxt = 1'b1;
            rdata_nxt   = ent_nxt[0].data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            rd_count     <= '0;
            dram_data_ok <= 1'b0;
            dram_rdata   <= '0;
            for (int i = 0; i < OUTSTANDING; i++) begin
                ent[i] <= '0;
            end
        end else begin
            rd_count     <= cnt_nxt;
            dram_data_ok <= data_ok_nxt;
            dram_rdata   <= rdata_nxt;
            for (int i = 0; i < OUTSTANDING; i++) begin
                ent[i] <= ent_nxt[i];
            end
        end
    end

    // Array contents survive reset; accept is already gated by rst_b.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (dram_wstrb[b]) begin
                    mem[idx][8*b +: 8] <= dram_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
